// File: rtl/mcp_tx_arbiter_pkg.sv
// Shared types and constants for the MCP transmit-side controller.
package mcp_pkg;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } mcp_tx_state_e;

  localparam int unsigned MCP_DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned MCP_MIN_TIMEOUT        = 8;

endpackage

// File: rtl/mcp_tx_arbiter_if.sv
// Requester, crossing and status signals of the MCP transmit controller.
interface mcp_tx_if
  import mcp_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = MCP_DEFAULT_DATA_WIDTH
);
  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic [DATA_WIDTH-1:0]         mcp_data;
  logic                          mcp_req_toggle;
  logic                          mcp_ack_pulse;
  logic                          busy;
  logic [ID_W-1:0]               grant_id;
  logic                          timeout_err;
  logic                          spurious_ack;

  modport slave (
    input  req_valid, req_data, mcp_ack_pulse,
    output req_ready, mcp_data, mcp_req_toggle, busy, grant_id, timeout_err, spurious_ack
  );

  modport master (
    output req_valid, req_data, mcp_ack_pulse,
    input  req_ready, mcp_data, mcp_req_toggle, busy, grant_id, timeout_err, spurious_ack
  );

endinterface

// File: rtl/mcp_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, else lowest set.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id
);

  logic found;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
        gnt_id = ID_W'(i);
      end
    end
    // Nothing at or above the pointer: wrap around to the lowest index.
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (!found && req[i]) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
        gnt_id = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/mcp_tx_arbiter.sv
// Source-domain MCP toggle/ack controller: arbitrates requesters onto one
// stable data register and waits for the synchronised destination ack.
module mcp_tx_arbiter
  import mcp_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_WIDTH     = MCP_DEFAULT_DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic     clk,
  input  logic     reset_n,
  mcp_tx_if.slave  bus
);

  localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [0:0] ST_IDLE     = IDLE;
  localparam logic [0:0] ST_WAIT_ACK = WAIT_ACK;

  logic [0:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q,  data_d;
  logic                  tog_q,   tog_d;
  logic [ID_W-1:0]       gid_q,   gid_d;
  logic [ID_W-1:0]       ptr_q,   ptr_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;
  logic                  tmo_q,   tmo_d;
  logic                  spur_q,  spur_d;

  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [ID_W-1:0]    arb_id;

  assign arb_req = (state_q == ST_IDLE) ? bus.req_valid : '0;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .req    (arb_req),
    .ptr    (ptr_q),
    .gnt    (arb_gnt),
    .gnt_id (arb_id)
  );

  // Ready is the only combinational output; held low while in reset.
  assign bus.req_ready      = arb_gnt & {NUM_REQ{reset_n}};
  assign bus.mcp_data       = data_q;
  assign bus.mcp_req_toggle = tog_q;
  assign bus.busy           = (state_q == ST_WAIT_ACK);
  assign bus.grant_id       = gid_q;
  assign bus.timeout_err    = tmo_q;
  assign bus.spurious_ack   = spur_q;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    tog_d   = tog_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    spur_d  = spur_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.mcp_ack_pulse) spur_d = 1'b1;
        if (|arb_gnt) begin
          for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (arb_gnt[i]) data_d = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
          end
          tog_d   = ~tog_q;
          gid_d   = arb_id;
          ptr_d   = (arb_id == ID_W'(NUM_REQ - 1)) ? '0 : arb_id + ID_W'(1);
          cnt_d   = '0;
          state_d = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        // Data and toggle stay frozen; only the wait counter advances.
        if (cnt_q != CNT_W'(TIMEOUT_CYCLES)) cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1)) tmo_d = 1'b1;
        if (bus.mcp_ack_pulse) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      tog_q   <= 1'b0;
      gid_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
      spur_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      tog_q   <= tog_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      spur_q  <= spur_d;
    end
  end

endmodule

// File: tb/tb_mcp_tx_arbiter.sv
// Self-checking bench for mcp_tx_arbiter: directed scenarios plus random
// traffic, all compared each cycle against a transaction-level model.
module tb_mcp_tx_arbiter;
  import mcp_pkg::*;

  localparam int unsigned N   = 3;
  localparam int unsigned DW  = 32;
  localparam int unsigned TO  = 8;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mcp_tx_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

  mcp_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] words [N];

  // Reference model state
  bit            m_busy;
  int            m_ptr;
  logic [DW-1:0] m_data;
  bit            m_tog;
  int            m_gid;
  int            m_cnt;
  bit            m_tmo;
  bit            m_spur;
  int            last_w;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int winner(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < int'(N); k++) begin
      int idx;
      idx = (ptr + k) % int'(N);
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic drive(input logic [N-1:0] v, input logic a);
    bus.req_valid     = v;
    bus.mcp_ack_pulse = a;
    for (int i = 0; i < int'(N); i++) bus.req_data[i*DW +: DW] = words[i];
  endtask

  task automatic model_reset();
    m_busy = 0; m_ptr = 0; m_data = '0; m_tog = 0;
    m_gid = 0; m_cnt = 0; m_tmo = 0; m_spur = 0;
  endtask

  task automatic check_outputs(input string pfx, input logic [N-1:0] er);
    chk({pfx, "req_ready"}, 64'(bus.req_ready), 64'(er));
    chk({pfx, "mcp_data"},  64'(bus.mcp_data), 64'(m_data));
    chk({pfx, "toggle"},    64'(bus.mcp_req_toggle), 64'(m_tog));
    chk({pfx, "busy"},      64'(bus.busy), 64'(m_busy));
    chk({pfx, "grant_id"},  64'(bus.grant_id), 64'(m_gid));
    chk({pfx, "timeout"},   64'(bus.timeout_err), 64'(m_tmo));
    chk({pfx, "spurious"},  64'(bus.spurious_ack), 64'(m_spur));
  endtask

  // Entered and left at posedge+1 with inputs already applied.
  task automatic cycle();
    int w;
    logic [N-1:0] er;
    @(negedge clk);
    w  = m_busy ? -1 : winner(bus.req_valid, m_ptr);
    er = '0;
    if (w >= 0) er[w] = 1'b1;
    check_outputs("", er);
    @(posedge clk);
    if (m_busy) begin
      if (m_cnt < int'(TO)) m_cnt++;
      if (m_cnt == int'(TO)) m_tmo = 1;
      if (bus.mcp_ack_pulse) m_busy = 0;
    end else begin
      if (bus.mcp_ack_pulse) m_spur = 1;
      if (w >= 0) begin
        m_data = words[w];
        m_tog  = ~m_tog;
        m_gid  = w;
        m_ptr  = (w + 1) % int'(N);
        m_cnt  = 0;
        m_busy = 1;
      end
    end
    last_w = w;
    #1;
  endtask

  // Asynchronous reset mid-cycle; outputs must clear at once and ready stay low.
  task automatic do_reset();
    reset_n = 1'b0;
    drive('1, 1'b0);
    #1;
    model_reset();
    check_outputs("rst_", '0);
    @(posedge clk);
    @(negedge clk);
    drive('0, 1'b0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_words();
    for (int i = 0; i < int'(N); i++) words[i] = $urandom;
  endtask

  int order[$];

  initial begin
    for (int i = 0; i < int'(N); i++) words[i] = '0;
    last_w = -1;
    do_reset();

    // Single requester with ack five cycles after launch
    words[0] = 32'hDEADBEEF;
    drive(3'b001, 1'b0); cycle();
    chk("single_grant", 64'(last_w), 64'd0);
    drive(3'b000, 1'b0);
    repeat (4) cycle();
    chk("single_data", 64'(bus.mcp_data), 64'hDEADBEEF);
    chk("single_tog",  64'(bus.mcp_req_toggle), 64'd1);
    drive(3'b000, 1'b1); cycle();
    drive(3'b000, 1'b0); cycle();
    chk("single_busy_low", 64'(bus.busy), 64'd0);

    // Round-robin with everyone valid, ack three cycles after each launch
    do_reset();
    order.delete();
    for (int l = 0; l < 4; l++) begin
      rand_words();
      drive('1, 1'b0); cycle();
      order.push_back(last_w);
      drive('1, 1'b0); cycle(); cycle();
      drive('1, 1'b1); cycle();
    end
    chk("rr_0", 64'(order[0]), 64'd0);
    chk("rr_1", 64'(order[1]), 64'd1);
    chk("rr_2", 64'(order[2]), 64'd2);
    chk("rr_3", 64'(order[3]), 64'd0);

    // Pointer wrap: grant 2, then with 0 and 2 valid the next grant is 0
    do_reset();
    rand_words();
    drive(3'b100, 1'b0); cycle();
    chk("wrap_first", 64'(last_w), 64'd2);
    drive(3'b000, 1'b1); cycle();
    drive(3'b101, 1'b0); cycle();
    chk("wrap_second", 64'(last_w), 64'd0);
    drive(3'b000, 1'b1); cycle();

    // Timeout: withhold ack 20 cycles while others keep requesting
    do_reset();
    rand_words();
    drive(3'b010, 1'b0); cycle();
    drive('1, 1'b0);
    for (int c = 1; c <= 20; c++) begin
      cycle();
      if (c == 7) chk("tmo_before", 64'(bus.timeout_err), 64'd0);
      if (c == 8) chk("tmo_at",     64'(bus.timeout_err), 64'd1);
    end
    chk("tmo_data_held", 64'(bus.mcp_data), 64'(words[1]));
    drive(3'b000, 1'b1); cycle();
    drive(3'b000, 1'b0); cycle();
    chk("tmo_sticky", 64'(bus.timeout_err), 64'd1);

    // Spurious ack in IDLE, then a normal transfer
    do_reset();
    drive(3'b000, 1'b1); cycle();
    drive(3'b000, 1'b0); cycle();
    chk("spur_flag", 64'(bus.spurious_ack), 64'd1);
    chk("spur_idle", 64'(bus.busy), 64'd0);
    rand_words();
    drive(3'b010, 1'b0); cycle();
    drive(3'b000, 1'b0); cycle();
    drive(3'b000, 1'b1); cycle();
    drive(3'b000, 1'b0); cycle();

    // Reset while waiting for ack; first grant afterwards goes to 0
    rand_words();
    drive(3'b100, 1'b0); cycle();
    drive(3'b000, 1'b0); cycle(); cycle();
    do_reset();
    rand_words();
    drive('1, 1'b0); cycle();
    chk("post_rst_grant", 64'(last_w), 64'd0);
    drive('0, 1'b1); cycle();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      logic a;
      rand_words();
      if (m_busy) a = ($urandom_range(0, 3) == 0);
      else        a = ($urandom_range(0, 19) == 0);
      drive(N'($urandom), a);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
